// File: rtl/date_encoder.sv
// Converts month plus BCD day-of-month (Jan..Apr) to a 0-based day-of-year.
// Build option: DATE_ENCODER_LEAP_EN makes leapYear select a 29-day February.
module date_encoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] month,
  input  logic [1:0] dayTens,
  input  logic [3:0] dayOnes,
  input  logic       leapYear,
  output logic [6:0] date,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned DateW = 7;
  localparam int unsigned DayW  = 6;
  localparam int unsigned LenW  = 5;

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, DONE} state_t;

  state_t            state;
  state_t            nextState;
  logic [1:0]        monthQ;
  logic [1:0]        tensQ;
  logic [3:0]        onesQ;
  logic [DateW-1:0]  acc;
  logic [1:0]        cnt;
  logic [LenW-1:0]   febLen;
  logic [LenW-1:0]   checkLen;
  logic [LenW-1:0]   accLen;
  logic [DayW-1:0]   dayBin;
  logic              invalid;
  logic [DateW-1:0]  accSum;

`ifdef DATE_ENCODER_LEAP_EN
  logic leapQ;
  assign febLen = leapQ ? LenW'(29) : LenW'(28);
`else
  logic unusedLeap;
  assign unusedLeap = leapYear;
  assign febLen     = LenW'(28);
`endif

  function automatic logic [LenW-1:0] monthLen(input logic [1:0] idx, input logic [LenW-1:0] feb);
    case (idx)
      2'd0:    monthLen = LenW'(31);
      2'd1:    monthLen = feb;
      2'd2:    monthLen = LenW'(31);
      default: monthLen = LenW'(30);
    endcase
  endfunction

  // Six bits so that days 32..39 are rejected instead of aliasing onto 0..7.
  assign dayBin   = DayW'(tensQ) * DayW'(10) + DayW'(onesQ);
  assign checkLen = monthLen(monthQ, febLen);
  assign accLen   = monthLen(cnt, febLen);
  assign invalid  = (onesQ > 4'd9) || (dayBin == '0) || (dayBin > DayW'(checkLen));
  assign accSum   = acc + DateW'(accLen);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CHECK;
      CHECK: begin
        if (invalid || monthQ == 2'd0) nextState = DONE;
        else                           nextState = ACCUM;
      end
      ACCUM:   if (cnt == 2'(monthQ - 2'd1)) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      monthQ <= '0;
      tensQ  <= '0;
      onesQ  <= '0;
`ifdef DATE_ENCODER_LEAP_EN
      leapQ  <= 1'b0;
`endif
      acc    <= '0;
      cnt    <= '0;
      date   <= '0;
      error  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (nextState == CHECK) || (nextState == ACCUM);
      done <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            monthQ <= month;
            tensQ  <= dayTens;
            onesQ  <= dayOnes;
`ifdef DATE_ENCODER_LEAP_EN
            leapQ  <= leapYear;
`endif
          end
        end
        CHECK: begin
          if (invalid) begin
            date  <= '0;
            error <= 1'b1;
          end else begin
            acc <= DateW'(dayBin) - DateW'(1);
            cnt <= '0;
            if (monthQ == 2'd0) begin
              date  <= DateW'(dayBin) - DateW'(1);
              error <= 1'b0;
            end
          end
        end
        ACCUM: begin
          acc <= accSum;
          cnt <= cnt + 2'd1;
          if (nextState == DONE) begin
            date  <= accSum;
            error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_date_encoder.sv
// Directed bench for date_encoder: calendar-level model checked every cycle,
// plus literal expectations per request. Honours DATE_ENCODER_LEAP_EN.
module tb_date_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] month;
  logic [1:0] dayTens;
  logic [3:0] dayOnes;
  logic       leapYear;
  logic [6:0] date;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

`ifdef DATE_ENCODER_LEAP_EN
  localparam bit LeapEn = 1'b1;
`else
  localparam bit LeapEn = 1'b0;
`endif

  date_encoder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .month(month),
    .dayTens(dayTens), .dayOnes(dayOnes), .leapYear(leapYear),
    .date(date), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Calendar model: day-of-year from month lengths, or an error flag.
  function automatic void calc(input int m, input int t, input int o, input bit l,
                               output int d, output bit e);
    int lens[4];
    int day;
    lens[0] = 31;
    lens[1] = (LeapEn && l) ? 29 : 28;
    lens[2] = 31;
    lens[3] = 30;
    day = t * 10 + o;
    e = (o > 9) || (day == 0) || (day > lens[m]);
    d = 0;
    if (!e) begin
      for (int i = 0; i < m; i++) d += lens[i];
      d += day - 1;
    end
  endfunction

  // Timing model: a request takes 1+month edges (1 if invalid), then one done cycle.
  int  phase = -1;
  int  pendDate;
  bit  pendErr;
  int  mDate = 0;
  bit  mErr  = 1'b0;
  bit  mDone = 1'b0;
  bit  mBusy = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      phase = -1; mDate = 0; mErr = 1'b0; mDone = 1'b0; mBusy = 1'b0;
    end else if (phase == 0) begin
      phase = -1; mDone = 1'b0;
    end else if (phase > 0) begin
      phase--;
      if (phase == 0) begin
        mDone = 1'b1; mBusy = 1'b0; mDate = pendDate; mErr = pendErr;
      end
    end else if (start) begin
      calc(int'(month), int'(dayTens), int'(dayOnes), leapYear, pendDate, pendErr);
      phase = pendErr ? 1 : int'(month) + 1;
      mBusy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("cyc_done",  int'(done),  int'(mDone));
      check("cyc_busy",  int'(busy),  int'(mBusy));
      check("cyc_date",  int'(date),  mDate);
      check("cyc_error", int'(error), int'(mErr));
    end
  end

  task automatic runReq(input string name, input logic [1:0] m, input logic [1:0] t,
                        input logic [3:0] o, input bit l, input bit intrude,
                        input int expDate, input bit expErr, input int expLat);
    int  lat;
    bit  seen;
    @(negedge clk);
    month = m; dayTens = t; dayOnes = o; leapYear = l; start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    if (intrude) begin
      month = 2'd0; dayTens = 2'd0; dayOnes = 4'd5; leapYear = 1'b0;
      @(posedge clk); #1;
      lat = 0;
    end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL %s_timeout: no done within 12 cycles", name);
    end else begin
      check({name, "_lat"},   lat, expLat);
      check({name, "_date"},  int'(date), expDate);
      check({name, "_error"}, int'(error), int'(expErr));
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; month = '0; dayTens = '0; dayOnes = '0; leapYear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_date", int'(date), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    reset_n = 1'b1;
    chkEn = 1'b1;

    runReq("jan01",     2'd0, 2'd0, 4'd1, 1'b0, 1'b0, 0,   1'b0, 1);
    runReq("mar15",     2'd2, 2'd1, 4'd5, 1'b0, 1'b0, 73,  1'b0, 3);
    runReq("mar15_lp",  2'd2, 2'd1, 4'd5, 1'b1, 1'b0, LeapEn ? 74 : 73, 1'b0, 3);
    runReq("apr30_lp",  2'd3, 2'd3, 4'd0, 1'b1, 1'b0, LeapEn ? 120 : 119, 1'b0, 4);
    runReq("feb29",     2'd1, 2'd2, 4'd9, 1'b0, 1'b0, 0,   1'b1, 1);
    runReq("ones10",    2'd0, 2'd0, 4'd10, 1'b0, 1'b0, 0,  1'b1, 1);
    runReq("feb28",     2'd1, 2'd2, 4'd8, 1'b0, 1'b0, 58,  1'b0, 2);
    runReq("day00",     2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 0,   1'b1, 1);
    runReq("apr31",     2'd3, 2'd3, 4'd1, 1'b0, 1'b0, 0,   1'b1, 1);
    runReq("jan31",     2'd0, 2'd3, 4'd1, 1'b0, 1'b0, 30,  1'b0, 1);
    runReq("apr10_int", 2'd3, 2'd1, 4'd0, 1'b0, 1'b1, 99,  1'b0, 4);

    // Abort Apr 10 with a one-edge reset while accumulating.
    @(negedge clk);
    month = 2'd3; dayTens = 2'd1; dayOnes = 4'd0; leapYear = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_dones", n, 0);
    check("abort_date",  int'(date),  0);
    check("abort_busy",  int'(busy),  0);
    check("abort_error", int'(error), 0);
    runReq("jan02", 2'd0, 2'd0, 4'd2, 1'b0, 1'b0, 1, 1'b0, 1);

    // Start held high: a new request every third cycle.
    @(negedge clk);
    month = 2'd0; dayTens = 2'd0; dayOnes = 4'd1; leapYear = 1'b0; start = 1'b1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n++;
    end
    start = 1'b0;
    check("held_dones", n, 3);
    repeat (4) @(negedge clk);

    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
